rr_mux_ctrl: RTL
================

RR_MUX_CTRL -- requirements
Module: rr_mux_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters; the legal range is 2 to 16.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of each requester's data lane.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-005 Port req_i  input  NUM_REQ  SHALL carry the per-requester request bits.
REQ-006 Port data_i  input  NUM_REQ*DATA_W  SHALL carry the packed requester data; lane k is bits [k*DATA_W +: DATA_W].
REQ-007 Port ack_o  output  NUM_REQ  SHALL be the one-hot transfer acknowledge to the requesters.
REQ-008 Port sel_o  output  NUM_REQ  SHALL be the registered one-hot grant, which is also the mux select.
REQ-009 Port out_valid_o  output  1  SHALL indicate that out_data_o holds a granted beat.
REQ-010 Port out_ready_i  input  1  SHALL be consumer backpressure.
REQ-011 Port out_data_o  output  DATA_W  SHALL be the muxed data of the granted lane.

Function
REQ-012 The controller SHALL implement an FSM with the two states IDLE and GRANT.
REQ-013 In IDLE with req_i nonzero, the controller SHALL register a one-hot sel_o chosen round-robin starting at ptr and enter GRANT, giving 1-cycle latency from req to sel_o.
REQ-014 In IDLE with req_i zero, the controller SHALL keep sel_o at zero and hold ptr.
REQ-015 Round-robin priority SHALL be ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-016 In GRANT, out_valid_o SHALL be 1 and out_data_o SHALL equal the AND-OR of data_i lanes gated by sel_o, with no further latency.
REQ-017 Whenever the FSM is not in GRANT, out_valid_o SHALL be 0 and out_data_o SHALL be 0.
REQ-018 A transfer SHALL be defined as out_valid_o AND out_ready_i in the same cycle.
REQ-019 ack_o SHALL equal sel_o when a transfer occurs and 0 otherwise.
REQ-020 On a transfer, ptr SHALL become (granted index + 1) mod NUM_REQ.
REQ-021 On a transfer, the next grant SHALL be arbitrated in the same cycle from req_i & ~sel_o, using the updated ptr.
REQ-022 On a transfer, if req_i & ~sel_o is nonzero, the controller SHALL remain in GRANT with the new sel_o (back-to-back, no bubble).
REQ-023 On a transfer, if the granted requester is the only one requesting, the controller SHALL go to IDLE; it re-arbitrates from IDLE on the following cycle, leaving a one-cycle bubble.
REQ-024 While out_ready_i is 0 in GRANT, sel_o, ptr and out_data_o SHALL hold, and the grant SHALL NOT change even if higher-priority requests arrive.
REQ-025 Requesters SHALL hold req and data stable until ack.
REQ-026 If the granted requester's req bit drops while in GRANT with no transfer, the controller SHALL go to IDLE next cycle with sel_o set to 0, ptr unchanged, and no ack.
REQ-027 The req-drop rule SHALL be evaluated only when no transfer occurs; a transfer takes precedence over a simultaneous req drop.
REQ-028 sel_o SHALL be one-hot or zero in every cycle.

Reset
REQ-029 When reset_n is 0 at a clock edge, the controller SHALL set state IDLE, sel_o 0, ptr 0, out_valid_o 0, out_data_o 0 and ack_o 0.
REQ-030 Reset asserted mid-grant SHALL abandon the beat without issuing an ack.
REQ-031 The first grant after reset SHALL favour requester 0.
REQ-032 Inputs sampled during reset SHALL be ignored.

Structure
REQ-033 A shared package rr_mux_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the NUM_REQ_DEF and DATA_W_DEF constants.
REQ-034 The rotate-priority picker SHALL be a sub-module rr_pick (inputs req and ptr, output one-hot gnt), reused for both the IDLE and back-to-back decisions.
REQ-035 The data mux SHALL be an AND-OR tree, not a priority chain, so the output is X-free for a zero select.

Verification (NUM_REQ=4, DATA_W=8)
REQ-036 Reset: hold reset_n=0 with req_i=4'b1111 -> sel_o=0, out_valid_o=0; after release, sel_o=4'b0001 one cycle later.
REQ-037 Fairness: req_i=4'b1111 held, out_ready_i=1 -> sel_o sequence 0001,0010,0100,1000,0001, with no idle cycles between beats.
REQ-038 Backpressure: req_i=4'b0100, data lane 2=8'hA5, out_ready_i=0 for 3 cycles -> out_data_o=8'hA5 stable and ack_o=0 throughout; when out_ready_i goes to 1, ack_o=4'b0100 for one cycle.
REQ-039 Lone requester: req_i=4'b0010 held, out_ready_i=1 -> grants on alternating cycles (GRANT, IDLE, GRANT, ...), ptr=2 after the first ack.
REQ-040 Withdrawal: granted requester 3 with out_ready_i=0 drops req -> next cycle sel_o=0, state IDLE, ptr unchanged, no ack.
REQ-041 Mid-grant reset: reset_n=0 while sel_o=4'b1000 is stalled -> next cycle sel_o=0 and ptr=0, and no ack is ever issued for that beat.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared FSM state type, default sizes and one-hot index helper for rr_mux_ctrl
// NUM_REQ_DEF / DATA_W_DEF : default requester count and data lane width
// state_t                  : controller FSM states IDLE and GRANT
// oh_idx                   : index of the set bit of a one-hot vector up to 16 bits wide
package rr_mux_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [3:0] oh_idx(input logic [15:0] v);
    oh_idx = '0;
    for (int i = 0; i < 16; i++) if (v[i]) oh_idx = 4'(i);
  endfunction
endpackage

// File: rtl/rr_mux_ctrl_pick.sv
// rr_pick: rotate-priority picker, first set request bit scanning ptr, ptr+1, ... modulo N
// req : request vector
// ptr : highest-priority index
// gnt : one-hot grant, zero when no request is set
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [PW:0] w_k;
  logic        w_found;
  always_comb begin
    gnt = '0;
    w_found = 1'b0;
    w_k = '0;
    for (int i = 0; i < N; i++) begin
      w_k = {1'b0, ptr} + (PW + 1)'(i);
      w_k = (w_k >= (PW + 1)'(N)) ? w_k - (PW + 1)'(N) : w_k;
      if (!w_found && req[w_k[PW-1:0]]) begin
        gnt[w_k[PW-1:0]] = 1'b1;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_mux_ctrl.sv
// rr_mux_ctrl: round-robin arbiter driving an AND-OR data mux with a valid/ready output
// clk         : clock, rising edge
// reset_n     : synchronous active-low reset
// req_i       : per-requester request bits
// data_i      : packed requester data, lane k at [k*DATA_W +: DATA_W]
// ack_o       : one-hot acknowledge, equal to sel_o on a transfer
// sel_o       : registered one-hot grant / mux select
// out_valid_o : out_data_o holds a granted beat
// out_ready_i : consumer backpressure
// out_data_o  : data of the granted lane
module rr_mux_ctrl
  import rr_mux_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        sel_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_data_o
);
  localparam int PW = $clog2(NUM_REQ);
  state_t             r_state, w_state_nx;
  logic [NUM_REQ-1:0] r_sel, w_sel_nx, w_gnt_idle, w_gnt_b2b;
  logic [PW-1:0]      r_ptr, w_ptr_nx, w_ptr_xfer, w_idx;
  logic               w_grant, w_xfer;
  assign w_grant = (r_state == GRANT);
  // reset_n gates the transfer so a beat abandoned by reset is never acknowledged
  assign w_xfer = w_grant && out_ready_i && reset_n;
  assign w_idx = PW'(oh_idx(16'(r_sel)));
  assign w_ptr_xfer = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign sel_o = r_sel;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_idle (
    .req(req_i),
    .ptr(r_ptr),
    .gnt(w_gnt_idle)
  );
  // back-to-back pick excludes the lane being acked and starts past it
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_b2b (
    .req(req_i & ~r_sel),
    .ptr(w_ptr_xfer),
    .gnt(w_gnt_b2b)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_ptr <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sel <= w_sel_nx;
      r_ptr <= w_ptr_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx = r_sel;
    w_ptr_nx = r_ptr;
    if (!w_grant) begin
      w_state_nx = |req_i ? GRANT : IDLE;
      w_sel_nx = w_gnt_idle;
    end else if (w_xfer) begin
      w_ptr_nx = w_ptr_xfer;
      w_sel_nx = w_gnt_b2b;
      w_state_nx = |w_gnt_b2b ? GRANT : IDLE;
    end else if (!(|(req_i & r_sel))) begin
      w_state_nx = IDLE;
      w_sel_nx = '0;
    end
  end
  always_comb begin
    out_valid_o = w_grant;
    ack_o = w_xfer ? r_sel : '0;
    out_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++)
      out_data_o = out_data_o | (data_i[k*DATA_W +: DATA_W] & {DATA_W{r_sel[k] & w_grant}});
  end
endmodule
